quadrature_generator: RTL and testbench



---
 rtl/quadrature_generator.sv | 152 +++++++++++++++
 tb/tb_quadrature_generator.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_generator.sv
// Quadrature A/B transmitter: steps a downstream encoder decoder from the
// current produced count to a commanded target with programmable edge spacing.
module quadrature_generator #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WIDTH-1:0]     cmd_target,
  input  logic [DIV_WIDTH-1:0] half_period,
  output logic                 a,
  output logic                 b,
  output logic [WIDTH-1:0]     position,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned PW = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    TRAIL = 2'd2,
    COOL  = 2'd3
  } state_t;

  state_t               r_state;
  logic [DIV_WIDTH-1:0] r_timer;
  logic [PW-1:0]        r_phase;
  logic [WIDTH-1:0]     r_pos;
  logic [WIDTH-1:0]     r_target;
  logic [DIV_WIDTH-1:0] r_h;
  logic                 r_up;
  logic                 r_a;
  logic                 r_b;
  logic                 r_busy;
  logic                 r_ready;
  logic                 r_done;

  state_t               w_state_nxt;
  logic [DIV_WIDTH-1:0] w_timer_nxt;
  logic [PW-1:0]        w_phase_nxt;
  logic [WIDTH-1:0]     w_pos_nxt;
  logic [WIDTH-1:0]     w_target_nxt;
  logic [DIV_WIDTH-1:0] w_h_nxt;
  logic                 w_up_nxt;
  logic                 w_done_nxt;
  logic [WIDTH-1:0]     w_d;
  logic [PW-1:0]        w_phase_step;
  logic [WIDTH-1:0]     w_pos_step;

  assign w_d          = cmd_target - r_pos;
  assign w_phase_step = r_up ? (r_phase + PW'(1)) : (r_phase - PW'(1));
  assign w_pos_step   = r_up ? (r_pos + WIDTH'(1)) : (r_pos - WIDTH'(1));

  // Next-state logic: one phase transition per timer expiry in LEAD/TRAIL
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_phase_nxt  = r_phase;
    w_pos_nxt    = r_pos;
    w_target_nxt = r_target;
    w_h_nxt      = r_h;
    w_up_nxt     = r_up;
    w_done_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid && r_ready) begin
          w_target_nxt = cmd_target;
          w_h_nxt      = half_period;
          // Half-way distance resolves downward since its MSB is set
          w_up_nxt     = ~w_d[WIDTH-1];
          if (w_d == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = LEAD;
            w_timer_nxt = '0;
          end
        end
      end
      LEAD: begin
        if (r_timer == '0) begin
          w_phase_nxt = w_phase_step;
          w_pos_nxt   = w_pos_step;
          w_timer_nxt = r_h;
          w_state_nxt = TRAIL;
        end else begin
          w_timer_nxt = r_timer - DIV_WIDTH'(1);
        end
      end
      TRAIL: begin
        if (r_timer == '0) begin
          w_phase_nxt = w_phase_step;
          w_timer_nxt = r_h;
          w_state_nxt = (r_pos == r_target) ? COOL : LEAD;
        end else begin
          w_timer_nxt = r_timer - DIV_WIDTH'(1);
        end
      end
      COOL: begin
        if (r_timer == '0) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_timer_nxt = r_timer - DIV_WIDTH'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; phase maps 0..3 to {a,b} = 00,10,11,01
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_phase  <= '0;
      r_pos    <= '0;
      r_target <= '0;
      r_h      <= '0;
      r_up     <= 1'b0;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_phase  <= w_phase_nxt;
      r_pos    <= w_pos_nxt;
      r_target <= w_target_nxt;
      r_h      <= w_h_nxt;
      r_up     <= w_up_nxt;
      r_a      <= w_phase_nxt[1] ^ w_phase_nxt[0];
      r_b      <= w_phase_nxt[1];
      r_busy   <= (w_state_nxt != IDLE);
      r_ready  <= (w_state_nxt == IDLE);
      r_done   <= w_done_nxt;
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign position  = r_pos;
  assign busy      = r_busy;
  assign cmd_ready = r_ready;
  assign done      = r_done;

endmodule

// File: tb/tb_quadrature_generator.sv
// Directed bench for quadrature_generator with a looped-back quadrature decoder model.
module tb_quadrature_generator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_target = 8'd0;
  logic [15:0] half_period = 16'd0;
  logic        a;
  logic        b;
  logic [7:0]  position;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  quadrature_generator #(.WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_target  (cmd_target),
    .half_period (half_period),
    .a           (a),
    .b           (b),
    .position    (position),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decoder: count moves on the first transition away from a rest state
  logic [7:0] enc;
  logic [1:0] ab_q;
  always @(posedge clk) begin
    if (reset) begin
      enc  <= 8'd0;
      ab_q <= 2'b00;
    end else begin
      ab_q <= {a, b};
      case ({ab_q, a, b})
        4'b0010, 4'b1101: enc <= enc + 8'd1;
        4'b0001, 4'b1110: enc <= enc - 8'd1;
        default: ;
      endcase
    end
  end

  logic       mon_en = 1'b0;
  logic       rst_q = 1'b1;
  logic [7:0] pos_prev = 8'd0;
  logic [1:0] ab_prev_m = 2'b00;
  always @(negedge clk) begin
    if (mon_en && !reset && !rst_q) begin
      check("enc_loopback", 32'(enc), 32'(pos_prev));
      check("no_glitch", 32'(({a, b} ^ ab_prev_m) == 2'b11), 32'd0);
    end
    pos_prev  <= position;
    ab_prev_m <= {a, b};
    rst_q     <= reset;
  end

  task automatic move(input logic [7:0] tgt, input logic [15:0] h, input logic up,
                      input int steps, input logic [7:0] fin, input logic hold);
    int c;
    int last;
    int nedge;
    logic [1:0] abp;
    logic [1:0] abn;
    logic seen_done;
    c = 0;
    while (!cmd_ready && c < 100) begin
      @(posedge clk); #1; c++;
    end
    check("ready_before", 32'(cmd_ready), 32'd1);
    cmd_target  = tgt;
    half_period = h;
    cmd_valid   = 1'b1;
    abp = {a, b};
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    nedge = 0; last = 0; seen_done = 1'b0; c = 0;
    while (!seen_done && c < 2000) begin
      @(posedge clk); #1; c++;
      if (hold) cmd_target = 8'($urandom);
      abn = {a, b};
      if (abn != abp) begin
        if (nedge == 0) begin
          check("first_edge_cycle", 32'(c), 32'd1);
          check("first_toggle", 32'(abn ^ abp), up ? 32'd2 : 32'd1);
        end else begin
          check("edge_spacing", 32'(c - last), 32'(h) + 32'd1);
        end
        nedge++; last = c; abp = abn;
      end
      if (done) seen_done = 1'b1;
    end
    if (hold) cmd_valid = 1'b0;
    check("done_seen", 32'(seen_done), 32'd1);
    check("edge_count", 32'(nedge), 32'(2 * steps));
    check("done_cycle", 32'(c), 32'(last) + 32'(h) + 32'd1);
    check("final_pos", 32'(position), 32'(fin));
    check("ready_at_done", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    check("done_pulse", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("enc_final", 32'(enc), 32'(fin));
  endtask

  logic [1:0] exp_ab [6];
  logic [7:0] exp_pos [6];
  logic [1:0] abp0;
  int         wc;

  initial begin
    exp_ab  = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11};
    exp_pos = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    check("rst_a", 32'(a), 32'd0);
    check("rst_b", 32'(b), 32'd0);
    check("rst_pos", 32'(position), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);

    // T1: H=0 up to 3, exact edge sequence
    cmd_target = 8'd3; half_period = 16'd0; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    check("t1_ready_low", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("t1_ab", 32'({a, b}), 32'(exp_ab[i]));
      check("t1_pos", 32'(position), 32'(exp_pos[i]));
      check("t1_no_done", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    check("t1_done", 32'(done), 32'd1);
    check("t1_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    check("t1_enc", 32'(enc), 32'd3);

    // T2: down 2 with H=4
    move(8'd1, 16'd4, 1'b0, 2, 8'd1, 1'b0);
    // T3: wrap both directions
    move(8'd0, 16'd0, 1'b0, 1, 8'd0, 1'b0);
    move(8'd254, 16'd1, 1'b0, 2, 8'd254, 1'b0);
    move(8'd2, 16'd0, 1'b1, 4, 8'd2, 1'b0);
    // T4: half-range tie goes down, then no-op
    move(8'd0, 16'd3, 1'b0, 2, 8'd0, 1'b0);
    move(8'd128, 16'd0, 1'b0, 128, 8'd128, 1'b0);
    abp0 = {a, b};
    cmd_target = 8'd128; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    check("t4_noop_done", 32'(done), 32'd1);
    check("t4_noop_ready", 32'(cmd_ready), 32'd1);
    check("t4_noop_busy", 32'(busy), 32'd0);
    check("t4_noop_ab", 32'({a, b}), 32'(abp0));
    @(posedge clk); #1;
    check("t4_noop_done_low", 32'(done), 32'd0);
    check("t4_noop_pos", 32'(position), 32'd128);

    // T5: reset while in TRAIL of a multi-step move
    abp0 = {a, b};
    cmd_target = 8'd133; half_period = 16'd2; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    wc = 0;
    while ({a, b} == abp0 && wc < 20) begin
      @(posedge clk); #1; wc++;
    end
    check("t5_first_edge", 32'(wc), 32'd1);
    check("t5_pos_mid", 32'(position), 32'd129);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    check("t5_a", 32'(a), 32'd0);
    check("t5_b", 32'(b), 32'd0);
    check("t5_pos", 32'(position), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_ready", 32'(cmd_ready), 32'd1);
    move(8'd2, 16'd1, 1'b1, 2, 8'd2, 1'b0);

    // T6: cmd_valid held with changing target while busy
    move(8'd5, 16'd1, 1'b1, 3, 8'd5, 1'b1);
    repeat (3) @(posedge clk);
    #1 check("t6_stays_idle", 32'(position), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
